// File: rtl/rpi_spi_master_pkg.sv
// Shared SPI frame layout, R/nW encoding and master FSM state encoding.
package rpi_spi_master_pkg;

   // R/nW field encoding; this bit is the first one on the wire
   localparam logic SPI_RW_READ  = 1'b1;
   localparam logic SPI_RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SETUP    = 3'd1,
      S_SHIFT_LO = 3'd2,
      S_SHIFT_HI = 3'd3,
      S_HOLD     = 3'd4,
      S_GAP      = 3'd5
   } spi_state_e;

   // Frame = [R/nW][addr][data]
   function automatic int unsigned frame_bits(input int unsigned addr_bits,
                                              input int unsigned data_bits);
      return 1 + addr_bits + data_bits;
   endfunction

   function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/rpi_spi_clk_gen.sv
// Phase counter shared by every timed FSM state; flags the last cycle of a state.
module rpi_spi_clk_gen #(
   parameter int unsigned phase_w = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               run,
   input  logic               hi_phase,
   input  logic [phase_w-1:0] terminal,
   output logic               done,
   output logic               sample
);

   logic [phase_w-1:0] phase;

   assign done   = run && (phase == terminal);
   assign sample = done && hi_phase;

   // Count up within a state; restart whenever the state completes or the FSM is idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase <= '0;
      end else if (run && !done) begin
         phase <= phase + 1'b1;
      end else begin
         phase <= '0;
      end
   end

endmodule

// File: rtl/rpi_spi_master.sv
// SPI mode-0 master: one command becomes one chip-select frame [R/nW][addr][data].
module rpi_spi_master
   import rpi_spi_master_pkg::*;
#(
   parameter int unsigned num_of_addr_bits = 7,
   parameter int unsigned num_of_data_bits = 8,
   parameter int unsigned clk_half_period  = 8,
   parameter int unsigned cs_setup_cycles  = 4,
   parameter int unsigned cs_hold_cycles   = 4,
   parameter int unsigned cs_gap_cycles    = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_read,
   input  logic [num_of_addr_bits-1:0] cmd_addr,
   input  logic [num_of_data_bits-1:0] cmd_wdata,
   output logic                        rsp_valid,
   output logic [num_of_data_bits-1:0] rsp_rdata,
   output logic                        busy,
   output logic                        spi_cs0,
   output logic                        spi_clk,
   output logic                        spi_mosi,
   input  logic                        spi_miso
);

   localparam int unsigned FRAME_BITS = frame_bits(num_of_addr_bits, num_of_data_bits);
   localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);
   localparam int unsigned MAX_T      = max_of4(clk_half_period, cs_setup_cycles,
                                                cs_hold_cycles, cs_gap_cycles);
   localparam int unsigned PHASE_W    = $clog2(MAX_T + 1);

   localparam logic [PHASE_W-1:0] T_SETUP = PHASE_W'(cs_setup_cycles - 1);
   localparam logic [PHASE_W-1:0] T_HALF  = PHASE_W'(clk_half_period - 1);
   localparam logic [PHASE_W-1:0] T_HOLD  = PHASE_W'(cs_hold_cycles - 1);
   // GAP spends one extra cycle: the response cycle precedes the cs-low gap proper
   localparam logic [PHASE_W-1:0] T_GAP   = PHASE_W'(cs_gap_cycles);
   localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(FRAME_BITS - 1);

   if (clk_half_period < 4) begin : g_bad_half_period
      $error("rpi_spi_master: clk_half_period must be >= 4");
   end
   if (cs_gap_cycles < 2) begin : g_bad_gap
      $error("rpi_spi_master: cs_gap_cycles must be >= 2");
   end
   if (cs_setup_cycles < 1 || cs_hold_cycles < 1) begin : g_bad_setup_hold
      $error("rpi_spi_master: cs_setup_cycles and cs_hold_cycles must be >= 1");
   end
   if (num_of_addr_bits < 1 || num_of_data_bits < 1) begin : g_bad_widths
      $error("rpi_spi_master: address and data widths must be >= 1");
   end

   spi_state_e                state, state_next;
   logic [1:0]                rst_sync;
   logic                      rst_int_n;
   logic [FRAME_BITS-1:0]     frame, frame_next;
   logic [BIT_W-1:0]          bit_cnt;
   logic [num_of_data_bits-1:0] rx;
   logic [PHASE_W-1:0]        terminal;
   logic                      phase_done, sample;
   logic                      accept, shift_adv, last_bit, rsp_fire, cs_next;

   // Reset asserts asynchronously, releases on a clk edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end
   assign rst_int_n = rst_sync[1];

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign last_bit  = (bit_cnt == LAST_BIT);
   assign shift_adv = (state == S_SHIFT_HI) && phase_done;
   assign rsp_fire  = (state == S_HOLD) && phase_done;

   rpi_spi_clk_gen #(
      .phase_w (PHASE_W)
   ) u_clk_gen (
      .clk      (clk),
      .reset_n  (rst_int_n),
      .run      (busy),
      .hi_phase (state == S_SHIFT_HI),
      .terminal (terminal),
      .done     (phase_done),
      .sample   (sample)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and per-state phase terminal count
   always_comb begin
      state_next = state;
      terminal   = '0;
      unique case (state)
         S_IDLE: begin
            if (cmd_valid) state_next = S_SETUP;
         end
         S_SETUP: begin
            terminal = T_SETUP;
            if (phase_done) state_next = S_SHIFT_LO;
         end
         S_SHIFT_LO: begin
            terminal = T_HALF;
            if (phase_done) state_next = S_SHIFT_HI;
         end
         S_SHIFT_HI: begin
            terminal = T_HALF;
            if (phase_done) state_next = last_bit ? S_HOLD : S_SHIFT_LO;
         end
         S_HOLD: begin
            terminal = T_HOLD;
            if (phase_done) state_next = S_GAP;
         end
         S_GAP: begin
            terminal = T_GAP;
            if (phase_done) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Next frame contents: load on accept, shift after each non-final bit
   always_comb begin
      frame_next = frame;
      if (accept) begin
         frame_next = {cmd_read, cmd_addr, cmd_wdata};
      end else if (shift_adv && !last_bit) begin
         frame_next = FRAME_BITS'({frame, 1'b0});
      end
   end

   assign cs_next = (state_next == S_SETUP) || (state_next == S_SHIFT_LO) ||
                    (state_next == S_SHIFT_HI) || (state_next == S_HOLD);

   // Frame shift register, bit counter and MISO capture
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         frame   <= '0;
         bit_cnt <= '0;
         rx      <= '0;
      end else begin
         frame <= frame_next;
         if (accept) begin
            bit_cnt <= '0;
         end else if (shift_adv) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (sample) begin
            rx <= num_of_data_bits'({rx, spi_miso});
         end
      end
   end

   // Registered pin and response outputs, decoded from the next state so they track the FSM exactly
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         spi_cs0   <= 1'b0;
         spi_clk   <= 1'b0;
         spi_mosi  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         spi_cs0   <= cs_next;
         spi_clk   <= (state_next == S_SHIFT_HI);
         spi_mosi  <= cs_next && frame_next[FRAME_BITS-1];
         rsp_valid <= rsp_fire;
         if (rsp_fire) begin
            rsp_rdata <= rx;
         end
      end
   end

endmodule
